// File: rtl/ip_payload_length_buffer.sv
// Store-and-forward payload buffer that emits each packet's byte count ahead of its payload.
// Optional drop counter port enabled by defining IP_PAYLOAD_LEN_BUF_DROP_CNT_EN.
//   state  | meaning
//   S_PASS | storing bytes of the current packet, committing on tlast
//   S_DROP | discarding the rest of an oversize packet until its tlast
module ip_payload_length_buffer #(
  parameter int DEPTH          = 2048,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        sresetn,
  output logic        axis_i_tready,
  input  logic        axis_i_tvalid,
  input  logic        axis_i_tlast,
  input  logic [7:0]  axis_i_tdata,
  input  logic        axis_len_tready,
  output logic        axis_len_tvalid,
  output logic        axis_len_tlast,
  output logic [15:0] axis_len_tdata,
  input  logic        axis_o_tready,
  output logic        axis_o_tvalid,
  output logic        axis_o_tlast,
  output logic [7:0]  axis_o_tdata
`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(LEN_FIFO_DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [LW:0]   LF_FULL = (LW+1)'(LEN_FIFO_DEPTH);

  typedef enum logic {S_PASS = 1'b0, S_DROP = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] used, wr_inc;
  logic          full, lf_full, in_hs, wr_en, len_push, len_pop;

  logic [8:0]    mem [DEPTH];
  logic [8:0]    ram_q;
  logic          rd_issue, rd_v_q, out_v_q, skid_v_q, pop_o;
  logic [8:0]    out_q, skid_q;
  logic [1:0]    occ;

  logic [15:0]   lf_mem [LEN_FIFO_DEPTH];
  logic [LW-1:0] lf_wr_q, lf_rd_q;
  logic [LW:0]   lf_cnt_q;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (used == DEPTH_P);
  assign lf_full = (lf_cnt_q == LF_FULL);
  assign wr_inc  = wr_ptr_q + PW'(1);

  // Gated by reset so the input never looks ready while the block is held in reset.
  assign axis_i_tready = sresetn && ((state_q == S_DROP) || (!full && !lf_full));
  assign in_hs         = axis_i_tvalid && axis_i_tready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    len_push = 1'b0;
    case (state_q)
      S_PASS: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_inc;
          if (axis_i_tlast) begin
            len_push = 1'b1;
            cm_ptr_d = wr_inc;
            cnt_d    = '0;
          end else if ((wr_inc - cm_ptr_q) == DEPTH_P) begin
            // Packet cannot fit even in an empty buffer: rewind and discard it.
            state_d  = S_DROP;
            wr_ptr_d = cm_ptr_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DROP: begin
        if (in_hs && axis_i_tlast) state_d = S_PASS;
      end
      default: state_d = S_PASS;
    endcase
  end

  assign len_pop         = axis_len_tvalid && axis_len_tready;
  assign axis_len_tvalid = (lf_cnt_q != '0);
  assign axis_len_tdata  = axis_len_tvalid ? lf_mem[lf_rd_q] : '0;
  assign axis_len_tlast  = 1'b1;

  // Two output slots (out + skid); a read is issued only if its data has a slot to land in.
  assign pop_o    = out_v_q && axis_o_tready;
  assign occ      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_v_q} - {1'b0, pop_o};
  assign rd_issue = (rd_ptr_q != cm_ptr_q) && (occ < 2'd2);

  assign axis_o_tvalid = out_v_q;
  assign axis_o_tlast  = out_q[8];
  assign axis_o_tdata  = out_q[7:0];

  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_ptr_q[AW-1:0]] <= {axis_i_tlast, axis_i_tdata};
    if (rd_issue) ram_q <= mem[rd_ptr_q[AW-1:0]];
    if (len_push) lf_mem[lf_wr_q] <= cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q  <= S_PASS;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lf_wr_q  <= '0;
      lf_rd_q  <= '0;
      lf_cnt_q <= '0;
      rd_v_q   <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      cnt_q    <= cnt_d;

      if (len_push) lf_wr_q <= lf_wr_q + LW'(1);
      if (len_pop)  lf_rd_q <= lf_rd_q + LW'(1);
      if (len_push && !len_pop)      lf_cnt_q <= lf_cnt_q + (LW+1)'(1);
      else if (!len_push && len_pop) lf_cnt_q <= lf_cnt_q - (LW+1)'(1);

      rd_v_q <= rd_issue;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + PW'(1);

      if (pop_o) begin
        if (skid_v_q) begin
          out_q    <= skid_q;
          skid_v_q <= rd_v_q;
          if (rd_v_q) skid_q <= ram_q;
        end else begin
          out_v_q <= rd_v_q;
          if (rd_v_q) out_q <= ram_q;
        end
      end else if (rd_v_q) begin
        if (!out_v_q) begin
          out_v_q <= 1'b1;
          out_q   <= ram_q;
        end else begin
          skid_v_q <= 1'b1;
          skid_q   <= ram_q;
        end
      end
    end
  end

`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
  logic        drop_done;
  logic [15:0] drop_cnt_q;

  assign drop_done  = (state_q == S_DROP) && in_hs && axis_i_tlast;
  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn)                               drop_cnt_q <= '0;
    else if (drop_done && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ip_payload_length_buffer.sv
// Bench for ip_payload_length_buffer (DEPTH=16): scenario tasks against a packet-level queue model.
module tb_ip_payload_length_buffer;
  localparam int DEPTH = 16;
  localparam int LFD   = 4;

  logic        clk = 1'b0;
  logic        sresetn = 1'b1;
  logic        axis_i_tready;
  logic        axis_i_tvalid = 1'b0;
  logic        axis_i_tlast = 1'b0;
  logic [7:0]  axis_i_tdata = '0;
  logic        axis_len_tready = 1'b0;
  logic        axis_len_tvalid, axis_len_tlast;
  logic [15:0] axis_len_tdata;
  logic        axis_o_tready = 1'b0;
  logic        axis_o_tvalid, axis_o_tlast;
  logic [7:0]  axis_o_tdata;
`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  ip_payload_length_buffer #(.DEPTH(DEPTH), .LEN_FIFO_DEPTH(LFD)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
    .axis_len_tready(axis_len_tready), .axis_len_tvalid(axis_len_tvalid),
    .axis_len_tlast(axis_len_tlast), .axis_len_tdata(axis_len_tdata),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata)
`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  int checks = 0, errors = 0;
  int stab_err = 0, in_stalls = 0, in_hs_cnt = 0;
  bit o_rand = 0, o_man = 0, l_rand = 0, l_man = 0;
  logic [7:0]  pkt_q[$];
  logic [8:0]  exp_bytes[$], byte_obs[$];
  logic [15:0] exp_len[$], len_obs[$];
  logic        prev_o_stall = 0, prev_l_stall = 0;
  logic [8:0]  prev_o = '0;
  logic [15:0] prev_l = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    axis_o_tready   = o_rand ? 1'($urandom_range(1)) : o_man;
    axis_len_tready = l_rand ? 1'($urandom_range(1)) : l_man;
  end

  always @(negedge clk) begin
    if (!sresetn) begin
      prev_o_stall = 0;
      prev_l_stall = 0;
    end else begin
      if (prev_o_stall && (axis_o_tvalid !== 1'b1 || {axis_o_tlast, axis_o_tdata} !== prev_o)) stab_err++;
      if (prev_l_stall && (axis_len_tvalid !== 1'b1 || axis_len_tdata !== prev_l)) stab_err++;
      if (axis_len_tvalid && axis_len_tlast !== 1'b1) stab_err++;
      if (axis_o_tvalid && axis_o_tready) byte_obs.push_back({axis_o_tlast, axis_o_tdata});
      if (axis_len_tvalid && axis_len_tready) len_obs.push_back(axis_len_tdata);
      if (axis_i_tvalid && !axis_i_tready) in_stalls++;
      prev_o_stall = axis_o_tvalid && !axis_o_tready;
      prev_l_stall = axis_len_tvalid && !axis_len_tready;
      prev_o = {axis_o_tlast, axis_o_tdata};
      prev_l = axis_len_tdata;
    end
  end

  // Reference: a packet longer than DEPTH vanishes; otherwise its length and bytes appear in order.
  task automatic model_pkt();
    if (pkt_q.size() <= DEPTH) begin
      exp_len.push_back(16'(pkt_q.size()));
      foreach (pkt_q[i]) exp_bytes.push_back({1'(i == pkt_q.size() - 1), pkt_q[i]});
    end
  endtask

  // Must be called just after a rising edge; returns just after a rising edge.
  task automatic send_pkt(input int gap_pct, input int nbeats);
    int n, w;
    n = pkt_q.size();
    for (int i = 0; i < nbeats; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        axis_i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = pkt_q[i];
      axis_i_tlast  = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (axis_i_tready !== 1'b1 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 3000) begin
        errors++;
        $display("FAIL input_timeout: tready stayed %b, need 1 within 3000 cycles", axis_i_tready);
        break;
      end
      @(posedge clk); #1;
      in_hs_cnt++;
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int w = 0;
    while ((byte_obs.size() < exp_bytes.size() || len_obs.size() < exp_len.size()) && w < 8000) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 8000);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 sresetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({axis_i_tready, axis_len_tvalid, axis_o_tvalid, axis_o_tlast, axis_len_tlast} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, need 00001",
               {axis_i_tready, axis_len_tvalid, axis_o_tvalid, axis_o_tlast, axis_len_tlast});
    end
    checks++;
    if (axis_len_tdata !== 16'h0 || axis_o_tdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got len %h data %h, need 0000 00", axis_len_tdata, axis_o_tdata);
    end
`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_drop_count: got %h, need 0000", drop_count);
    end
`endif
    sresetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({axis_i_tready, axis_len_tvalid, axis_o_tvalid} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_idle: got %b, need 100", {axis_i_tready, axis_len_tvalid, axis_o_tvalid});
    end
  endtask

  task automatic test_single();
    bit ok;
    o_man = 1; l_man = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pkt_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model_pkt();
    send_pkt(0, 5);
    @(negedge clk);
    checks++;
    if (axis_len_tvalid !== 1'b1 || axis_len_tdata !== 16'd5) begin
      errors++;
      $display("FAIL single_len_latency: got v=%b d=%0d, need v=1 d=5", axis_len_tvalid, axis_len_tdata);
    end
    checks++;
    if (axis_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_out_early1: got tvalid=%b, need 0", axis_o_tvalid);
    end
    @(negedge clk);
    checks++;
    if (axis_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_out_early2: got tvalid=%b, need 0", axis_o_tvalid);
    end
    @(negedge clk);
    checks++;
    if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== 8'h01) begin
      errors++;
      $display("FAIL single_out_latency: got v=%b d=%h, need v=1 d=01", axis_o_tvalid, axis_o_tdata);
    end
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL single_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL single_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sizes[3] = '{3, 1, 7};
    o_man = 1; l_man = 0;
    repeat (2) @(negedge clk);
    in_stalls = 0;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      pkt_q.delete();
      for (int i = 0; i < sizes[p]; i++) pkt_q.push_back(8'(8'h10 * (p + 1) + i));
      model_pkt();
      send_pkt(0, sizes[p]);
    end
    checks++;
    if (in_stalls != 0) begin
      errors++;
      $display("FAIL b2b_input_stalls: got %0d stall cycles, need 0", in_stalls);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (len_obs.size() != 0 || byte_obs.size() != 11) begin
      errors++;
      $display("FAIL b2b_len_held: got %0d lens %0d bytes, need 0 11", len_obs.size(), byte_obs.size());
    end
    l_man = 1;
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL b2b_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL b2b_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
  endtask

  task automatic test_full();
    bit ok;
    o_man = 0; l_man = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pkt_q.delete();
    for (int i = 0; i < DEPTH; i++) pkt_q.push_back(8'(8'h80 + i));
    model_pkt();
    send_pkt(0, DEPTH);
    repeat (3) @(negedge clk);
    checks++;
    if (len_obs.size() != 1 || len_obs[0] !== 16'd16) begin
      errors++;
      $display("FAIL full_len16: got %0d lens (first %0d), need 1 len of 16",
               len_obs.size(), len_obs.size() > 0 ? len_obs[0] : 16'hFFFF);
    end
    pkt_q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    model_pkt();
    in_hs_cnt = 0;
    @(posedge clk); #1;
    fork
      send_pkt(0, 4);
      begin
        repeat (30) @(negedge clk);
        checks++;
        if (axis_i_tready !== 1'b0 || in_hs_cnt >= 4) begin
          errors++;
          $display("FAIL full_stall: got tready=%b accepted=%0d, need tready=0 accepted<4",
                   axis_i_tready, in_hs_cnt);
        end
        checks++;
        if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== 8'h80 || byte_obs.size() != 0) begin
          errors++;
          $display("FAIL full_hold_out: got v=%b d=%h n=%0d, need v=1 d=80 n=0",
                   axis_o_tvalid, axis_o_tdata, byte_obs.size());
        end
        o_man = 1;
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL full_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL full_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL full_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
  endtask

  task automatic test_oversize();
    bit ok;
    o_man = 1; l_man = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pkt_q.delete();
    for (int i = 0; i < 20; i++) pkt_q.push_back(8'(8'h40 + i));
    model_pkt();
    send_pkt(0, 20);
    repeat (6) @(negedge clk);
    checks++;
    if (len_obs.size() != 0 || byte_obs.size() != 0) begin
      errors++;
      $display("FAIL oversize_silent: got %0d lens %0d bytes, need 0 0", len_obs.size(), byte_obs.size());
    end
    @(posedge clk); #1;
    pkt_q = {8'hAA, 8'hBB};
    model_pkt();
    send_pkt(0, 2);
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL oversize_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL oversize_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL oversize_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
`ifdef IP_PAYLOAD_LEN_BUF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL oversize_drop_count: got %0d, need 1", drop_count);
    end
`endif
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
  endtask

  task automatic test_random();
    bit ok;
    int n;
    o_rand = 1; l_rand = 1;
    stab_err = 0;
    @(posedge clk); #1;
    for (int p = 0; p < 200; p++) begin
      n = ($urandom_range(9) == 0) ? int'($urandom_range(DEPTH + 8, DEPTH + 1))
                                   : int'($urandom_range(DEPTH, 1));
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(255)));
      model_pkt();
      send_pkt(50, n);
    end
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL random_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL random_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL random_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL random_stability: got %0d hold violations, need 0", stab_err);
    end
    o_rand = 0; l_rand = 0;
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    o_man = 0; l_man = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pkt_q = {8'h21, 8'h22, 8'h23};
    send_pkt(0, 3);
    repeat (4) @(negedge clk);
    checks++;
    if (axis_len_tvalid !== 1'b1 || axis_o_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: got len_v=%b o_v=%b, need 1 1", axis_len_tvalid, axis_o_tvalid);
    end
    @(posedge clk); #1;
    pkt_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    send_pkt(0, 3);
    #2 sresetn = 1'b0;
    #1;
    checks++;
    if ({axis_i_tready, axis_len_tvalid, axis_o_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_async: got %b, need 000", {axis_i_tready, axis_len_tvalid, axis_o_tvalid});
    end
    repeat (2) @(negedge clk);
    exp_len.delete(); exp_bytes.delete(); len_obs.delete(); byte_obs.delete();
    o_man = 1; l_man = 1;
    @(negedge clk);
    sresetn = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pkt_q = {8'h10, 8'h11};
    model_pkt();
    send_pkt(0, 2);
    wait_drain(ok);
    checks++;
    if (!ok || len_obs.size() != exp_len.size() || byte_obs.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL rstmid_counts: got %0d lens %0d bytes, need %0d %0d",
               len_obs.size(), byte_obs.size(), exp_len.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_len.size() && i < len_obs.size(); i++) begin
      checks++;
      if (len_obs[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL rstmid_len[%0d]: got %0d, need %0d", i, len_obs[i], exp_len[i]);
      end
    end
    for (int i = 0; i < exp_bytes.size() && i < byte_obs.size(); i++) begin
      checks++;
      if (byte_obs[i] !== exp_bytes[i]) begin
        errors++;
        $display("FAIL rstmid_byte[%0d]: got %h, need %h", i, byte_obs[i], exp_bytes[i]);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_oversize();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
